// File: rtl/pe_addsub_pipe.sv
// rtl/pe_addsub_pipe.sv - pipelined modular add/sub butterfly PE for the NTT/INTT datapath
//
// Purpose:
//   Computes one butterfly per enabled cycle. Each sample's mode selects
//   one of four results:
//   - (u+v mod Q, u-v mod Q)
//   - the same pair halved mod Q
//   - pass (u, v)
//   - swap (v, u)
//   IN_DEPTH input stages sit before the arithmetic and OUT_DEPTH output
//   stages sit after it, so the latency can match the multiplier PE.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   en         pipeline advance, 0 freezes every stage
//   in_valid   u/v/mode carry a sample this cycle
//   mode       00 fwd, 01 inv-half, 10 pass, 11 swap
//   u, v       operands in [0, Q-1]
//   out_valid  bf_upper/bf_lower carry a result
//   bf_upper   upper result
//   bf_lower   lower result
//   busy       any stage holds a valid sample
module pe_addsub_pipe #(
  parameter int DATA_WIDTH = 12,
  parameter int Q          = 3329,
  parameter int IN_DEPTH   = 3,
  parameter int OUT_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] u,
  input  logic [DATA_WIDTH-1:0] v,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] bf_upper,
  output logic [DATA_WIDTH-1:0] bf_lower,
  output logic                  busy
);

  localparam int W = DATA_WIDTH;
  localparam logic [W:0] QX = (W+1)'(Q);

  // input stage chain: {valid, mode, u, v}
  logic [IN_DEPTH-1:0] in_vld;
  logic [1:0]          in_mode [IN_DEPTH];
  logic [W-1:0]        in_u    [IN_DEPTH];
  logic [W-1:0]        in_v    [IN_DEPTH];

  // output stage chain: {valid, upper, lower}
  logic [OUT_DEPTH-1:0] out_vld;
  logic [W-1:0]         out_up [OUT_DEPTH];
  logic [W-1:0]         out_lo [OUT_DEPTH];

  // Data registers load on every enabled edge whatever the valid bit says;
  // only the valid bits decide what downstream treats as a sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_vld <= '0;
      for (int i = 0; i < IN_DEPTH; i++) begin
        in_mode[i] <= '0;
        in_u[i]    <= '0;
        in_v[i]    <= '0;
      end
    end else if (en) begin
      in_vld[0]  <= in_valid;
      in_mode[0] <= mode;
      in_u[0]    <= u;
      in_v[0]    <= v;
      for (int i = 1; i < IN_DEPTH; i++) begin
        in_vld[i]  <= in_vld[i-1];
        in_mode[i] <= in_mode[i-1];
        in_u[i]    <= in_u[i-1];
        in_v[i]    <= in_v[i-1];
      end
    end
  end

  // Arithmetic on the last input stage, one guard bit wide.
  logic [W:0]   a_u, a_v, s_raw, d_raw;
  logic [W-1:0] sum_r, diff_r;
  logic [W-1:0] res_up, res_lo;

  assign a_u   = {1'b0, in_u[IN_DEPTH-1]};
  assign a_v   = {1'b0, in_v[IN_DEPTH-1]};
  assign s_raw = a_u + a_v;
  assign d_raw = a_u - a_v;
  assign sum_r  = W'((s_raw >= QX) ? s_raw - QX : s_raw);
  // The guard bit of d_raw is set exactly when u < v, because both are < 2^W.
  assign diff_r = W'(d_raw[W] ? d_raw + QX : d_raw);

  // x/2 mod Q for x < Q: an odd x is made even by adding the odd modulus.
  function automatic logic [W-1:0] half(input logic [W-1:0] x);
    logic [W:0] t;
    t = x[0] ? ({1'b0, x} + QX) : {1'b0, x};
    return t[W:1];
  endfunction

  always_comb begin
    res_up = sum_r;
    res_lo = diff_r;
    case (in_mode[IN_DEPTH-1])
      2'b00: begin
        res_up = sum_r;
        res_lo = diff_r;
      end
      2'b01: begin
        res_up = half(sum_r);
        res_lo = half(diff_r);
      end
      2'b10: begin
        res_up = in_u[IN_DEPTH-1];
        res_lo = in_v[IN_DEPTH-1];
      end
      default: begin
        res_up = in_v[IN_DEPTH-1];
        res_lo = in_u[IN_DEPTH-1];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        out_up[i] <= '0;
        out_lo[i] <= '0;
      end
    end else if (en) begin
      out_vld[0] <= in_vld[IN_DEPTH-1];
      out_up[0]  <= res_up;
      out_lo[0]  <= res_lo;
      for (int i = 1; i < OUT_DEPTH; i++) begin
        out_vld[i] <= out_vld[i-1];
        out_up[i]  <= out_up[i-1];
        out_lo[i]  <= out_lo[i-1];
      end
    end
  end

  assign out_valid = out_vld[OUT_DEPTH-1];
  assign bf_upper  = out_up[OUT_DEPTH-1];
  assign bf_lower  = out_lo[OUT_DEPTH-1];
  assign busy      = (|in_vld) | (|out_vld);

endmodule

// File: tb/tb_pe_addsub_pipe.sv
// tb/tb_pe_addsub_pipe.sv - directed and scoreboard checks for pe_addsub_pipe
module tb_pe_addsub_pipe;

  localparam int W = 12;
  localparam int Q = 3329;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] u = '0;
  logic [W-1:0] v = '0;
  logic         out_valid;
  logic [W-1:0] bf_upper;
  logic [W-1:0] bf_lower;
  logic         busy;

  int checks = 0;
  int failures = 0;

  logic [1:0] bm [8];
  int         bu [8];
  int         bv [8];
  int         eu [8];
  int         el [8];

  logic [23:0] sbq [$];

  always #5 clk = ~clk;

  pe_addsub_pipe #(.DATA_WIDTH(W), .Q(Q), .IN_DEPTH(3), .OUT_DEPTH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .mode      (mode),
    .u         (u),
    .v         (v),
    .out_valid (out_valid),
    .bf_upper  (bf_upper),
    .bf_lower  (bf_lower),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic vl, input logic [1:0] m, input int a, input int b);
    en       = e;
    in_valid = vl;
    mode     = m;
    u        = W'(a);
    v        = W'(b);
  endtask

  // Reference results: halving is multiplication by the inverse of 2 mod Q.
  function automatic logic [23:0] model(input logic [1:0] m, input int a, input int b);
    int s, d;
    s = (a + b) % Q;
    d = (a - b + Q) % Q;
    case (m)
      2'b00:   return {12'(s), 12'(d)};
      2'b01:   return {12'((s * ((Q + 1) / 2)) % Q), 12'((d * ((Q + 1) / 2)) % Q)};
      2'b10:   return {12'(a), 12'(b)};
      default: return {12'(b), 12'(a)};
    endcase
  endfunction

  function automatic int pick();
    int r;
    r = $urandom_range(0, 99);
    if (r < 5)  return 0;
    if (r < 10) return 1;
    if (r < 15) return Q - 1;
    return $urandom_range(0, Q - 1);
  endfunction

  // Feed n back-to-back samples from the b* tables and expect the e* tables
  // six edges later, followed by an idle pipeline.
  task automatic burst(input int n, input string tag);
    for (int t = 1; t <= n + 6; t++) begin
      if (t <= n) drive(1'b1, 1'b1, bm[t-1], bu[t-1], bv[t-1]);
      else        drive(1'b1, 1'b0, 2'b00, 0, 0);
      tick();
      if (t == 1) chk({tag, "_busy_rise"}, busy, 1);
      if (t == 5) chk({tag, "_early"}, out_valid, 0);
      if (t >= 6 && t <= n + 5) begin
        chk($sformatf("%s_valid%0d", tag, t - 6), out_valid, 1);
        chk($sformatf("%s_upper%0d", tag, t - 6), bf_upper, eu[t-6]);
        chk($sformatf("%s_lower%0d", tag, t - 6), bf_lower, el[t-6]);
      end
      if (t == n + 6) begin
        chk({tag, "_tail_valid"}, out_valid, 0);
        chk({tag, "_busy_fall"}, busy, 0);
      end
    end
  endtask

  initial begin
    logic [24:0] prev;
    logic [23:0] exp;
    logic        e, vl;
    logic [1:0]  m;
    int          a, b;

    // reset state
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_upper", bf_upper, 0);
    chk("rst_lower", bf_lower, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;

    // forward
    bm[0] = 2'b00; bu[0] = 3000; bv[0] = 1000; eu[0] = 671;  el[0] = 2000;
    bm[1] = 2'b00; bu[1] = 5;    bv[1] = 10;   eu[1] = 15;   el[1] = 3324;
    burst(2, "fwd");

    // inverse with halving
    bm[0] = 2'b01; bu[0] = 3000; bv[0] = 1000; eu[0] = 2000; el[0] = 1000;
    bm[1] = 2'b01; bu[1] = 5;    bv[1] = 10;   eu[1] = 1672; el[1] = 1662;
    bm[2] = 2'b01; bu[2] = 0;    bv[2] = 0;    eu[2] = 0;    el[2] = 0;
    burst(3, "inv");

    // pass/swap interleaved
    for (int i = 0; i < 4; i++) begin
      bm[i] = (i % 2 == 0) ? 2'b10 : 2'b11;
      bu[i] = 7;
      bv[i] = 9;
      eu[i] = (i % 2 == 0) ? 7 : 9;
      el[i] = (i % 2 == 0) ? 9 : 7;
    end
    burst(4, "pswap");

    // modulus boundaries
    bm[0] = 2'b00; bu[0] = Q-1; bv[0] = Q-1; eu[0] = 3327; el[0] = 0;
    bm[1] = 2'b00; bu[1] = 0;   bv[1] = Q-1; eu[1] = 3328; el[1] = 1;
    bm[2] = 2'b01; bu[2] = Q-1; bv[2] = 0;   eu[2] = 1664; el[2] = 1664;
    burst(3, "bound");

    // stall: en low on cycles 4..6, samples i = 1..8 give (103*i, 97*i)
    begin
      int idx;
      idx = 1;
      for (int c = 1; c <= 17; c++) begin
        if (c >= 4 && c <= 6) begin
          drive(1'b0, 1'b1, 2'b00, 999, 1);
        end else if (idx <= 8) begin
          drive(1'b1, 1'b1, 2'b00, 100 * idx, 3 * idx);
          idx++;
        end else begin
          drive(1'b1, 1'b0, 2'b00, 0, 0);
        end
        tick();
        if (c >= 4 && c <= 6) begin
          chk("stall_busy", busy, 1);
          chk("stall_valid", out_valid, 0);
        end
        if (c == 8 || c == 17) chk($sformatf("stall_idle%0d", c), out_valid, 0);
        if (c >= 9 && c <= 16) begin
          chk($sformatf("stall_valid%0d", c - 8), out_valid, 1);
          chk($sformatf("stall_upper%0d", c - 8), bf_upper, 103 * (c - 8));
          chk($sformatf("stall_lower%0d", c - 8), bf_lower, 97 * (c - 8));
        end
      end
    end

    // reset mid-stream
    for (int c = 1; c <= 2; c++) begin
      drive(1'b1, 1'b1, 2'b00, 10 * c, c);
      tick();
    end
    chk("mrst_busy_before", busy, 1);
    drive(1'b1, 1'b1, 2'b00, 30, 3);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_upper", bf_upper, 0);
    chk("mrst_lower", bf_lower, 0);
    tick();
    drive(1'b1, 1'b0, 2'b00, 0, 0);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk($sformatf("mrst_quiet%0d", c), out_valid, 0);
    end

    // random stream against the reference model
    for (int n = 0; n < 3030; n++) begin
      if (n < 3000) begin
        e  = ($urandom_range(0, 9) != 0);
        vl = ($urandom_range(0, 3) != 0);
      end else begin
        e  = 1'b1;
        vl = 1'b0;
      end
      m = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      drive(e, vl, m, a, b);
      if (e && vl) sbq.push_back(model(m, a, b));
      prev = {out_valid, bf_upper, bf_lower};
      tick();
      if (!e) begin
        chk("rnd_hold", {out_valid, bf_upper, bf_lower}, prev);
      end else if (out_valid) begin
        chk("rnd_underflow", (sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          exp = sbq.pop_front();
          chk("rnd_result", {bf_upper, bf_lower}, exp);
        end
      end
    end
    chk("rnd_missing", sbq.size(), 0);
    chk("rnd_busy_end", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
